// File: rtl/matrix_frame_scheduler_pkg.sv
// Shared definitions for the 8x8 LED matrix frame scheduler.
//   FRAME_W/ROWS/COLS : frame geometry (row k occupies bits [8k+7:8k])
//   SRC_A/SRC_B       : requester encoding used for priority and source tracking
//   frame_buf_t       : a buffered frame together with the producer it came from
package matrix_frame_scheduler_pkg;

  localparam int FRAME_W = 64;
  localparam int ROWS    = 8;
  localparam int COLS    = 8;
  localparam int ROW_W   = 3;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef struct packed {
    logic [FRAME_W-1:0] data;
    logic               src;
  } frame_buf_t;

  // Column byte for row k of a frame.
  function automatic logic [COLS-1:0] row_slice(input logic [FRAME_W-1:0] f,
                                                input logic [ROW_W-1:0]   k);
    return f[int'(k)*COLS +: COLS];
  endfunction

  // One-hot row select for row k.
  function automatic logic [ROWS-1:0] row_onehot(input logic [ROW_W-1:0] k);
    return ROWS'(1) << k;
  endfunction

endpackage

// File: rtl/matrix_frame_scheduler_scan_timer.sv
// Row dwell timer for the LED matrix scan.
// tick counts 0..SCAN_DIV-1; each wrap advances row_idx modulo 8.
// Ports:
//   i_clk, i_rst     : clock, asynchronous active-high reset
//   o_boundary       : last cycle of the frame (tick==SCAN_DIV-1, row_idx==7)
//   o_row_idx        : row currently being scanned
//   o_in_deadtime    : high for the first DEADTIME cycles of each row slot
module matrix_frame_scheduler_scan_timer
  import matrix_frame_scheduler_pkg::*;
#(
  parameter int SCAN_DIV = 65536,
  parameter int DEADTIME = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_boundary,
  output logic [ROW_W-1:0] o_row_idx,
  output logic             o_in_deadtime
);

  localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(SCAN_DIV - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(ROWS - 1);

  logic [TICK_W-1:0] r_tick;
  logic [ROW_W-1:0]  r_row_idx;
  logic              w_tick_wrap;

  assign w_tick_wrap = (r_tick == TICK_MAX);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tick    <= '0;
      r_row_idx <= '0;
    end else if (w_tick_wrap) begin
      r_tick    <= '0;
      r_row_idx <= r_row_idx + ROW_W'(1);
    end else begin
      r_tick    <= r_tick + TICK_W'(1);
    end
  end

  assign o_boundary = w_tick_wrap && (r_row_idx == ROW_MAX);
  assign o_row_idx  = r_row_idx;

  // A zero deadtime would make the comparison constant, so it is special-cased.
  generate
    if (DEADTIME == 0) begin : g_no_dead
      assign o_in_deadtime = 1'b0;
    end else begin : g_dead
      assign o_in_deadtime = (r_tick < TICK_W'(DEADTIME));
    end
  endgenerate

endmodule

// File: rtl/matrix_frame_scheduler.sv
// Scan sequencer and round-robin arbiter for an 8x8 LED matrix.
// Two producers (A, B) offer 64-bit frames over valid/ready; an accepted frame
// lands in the back buffer and is promoted to the front buffer only at a frame
// boundary, so the displayed image never tears.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   a_valid/a_data/a_ready, b_valid/b_data/b_ready : producer handshakes
//   blank               : forces row/column dark while scanning continues
//   row, column         : registered one-hot row select and column data
//   frame_tick          : registered one-cycle pulse after each frame boundary
//   src_b               : producer of the displayed frame (0 = A, 1 = B)
module matrix_frame_scheduler
  import matrix_frame_scheduler_pkg::*;
#(
  parameter int SCAN_DIV = 65536,
  parameter int DEADTIME = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_valid,
  input  logic [FRAME_W-1:0] a_data,
  output logic               a_ready,
  input  logic               b_valid,
  input  logic [FRAME_W-1:0] b_data,
  output logic               b_ready,
  input  logic               blank,
  output logic [ROWS-1:0]    row,
  output logic [COLS-1:0]    column,
  output logic               frame_tick,
  output logic               src_b
);

  logic             w_boundary;
  logic             w_in_deadtime;
  logic [ROW_W-1:0] w_row_idx;

  logic [FRAME_W-1:0] r_front;
  frame_buf_t         r_back;
  logic               r_pending;
  logic               r_prio;
  logic               r_src_b;
  // Stays low until the first swap so the matrix is dark, not a lit row of
  // empty columns, before any frame has been shown.
  logic               r_front_vld;

  logic [ROWS-1:0] r_row;
  logic [COLS-1:0] r_column;
  logic            r_frame_tick;

  logic w_a_ready;
  logic w_b_ready;
  logic w_a_xfer;
  logic w_b_xfer;

  matrix_frame_scheduler_scan_timer #(
    .SCAN_DIV (SCAN_DIV),
    .DEADTIME (DEADTIME)
  ) u_scan_timer (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_boundary    (w_boundary),
    .o_row_idx     (w_row_idx),
    .o_in_deadtime (w_in_deadtime)
  );

  // A lone requester is always granted; on contention prio decides. The two
  // readies can never both be high while both valids are high, so at most one
  // transfer happens per cycle.
  assign w_a_ready = ~r_pending & (~b_valid | (r_prio == SRC_A));
  assign w_b_ready = ~r_pending & (~a_valid | (r_prio == SRC_B));
  assign w_a_xfer  = a_valid & w_a_ready;
  assign w_b_xfer  = b_valid & w_b_ready;

  // Buffer and arbitration state. A transfer requires pending=0 and a swap
  // requires pending=1, so a transfer on the boundary cycle loads back without
  // swapping and that frame waits for the following boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_front     <= '0;
      r_back      <= '0;
      r_pending   <= 1'b0;
      r_prio      <= SRC_A;
      r_src_b     <= 1'b0;
      r_front_vld <= 1'b0;
    end else if (w_a_xfer || w_b_xfer) begin
      r_back.data <= w_a_xfer ? a_data : b_data;
      r_back.src  <= w_a_xfer ? SRC_A : SRC_B;
      r_pending   <= 1'b1;
      r_prio      <= w_a_xfer ? SRC_B : SRC_A;
    end else if (w_boundary && r_pending) begin
      r_front     <= r_back.data;
      r_src_b     <= r_back.src;
      r_front_vld <= 1'b1;
      r_pending   <= 1'b0;
    end
  end

  // Output stage: registered from the current-cycle scan state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row        <= '0;
      r_column     <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      if (blank || w_in_deadtime || !r_front_vld) begin
        r_row    <= '0;
        r_column <= '0;
      end else begin
        r_row    <= row_onehot(w_row_idx);
        r_column <= row_slice(r_front, w_row_idx);
      end
      r_frame_tick <= w_boundary;
    end
  end

  assign a_ready    = w_a_ready;
  assign b_ready    = w_b_ready;
  assign row        = r_row;
  assign column     = r_column;
  assign frame_tick = r_frame_tick;
  assign src_b      = r_src_b;

endmodule
